// File: rtl/led_scanner.sv
// Multi-channel PWM scanner: a position accumulator sweeps a lit point across the LEDs,
// with adjacent channels cross-faded. Define LED_SCANNER_FULL_ON_EN for 100% duty at full brightness.
module led_scanner #(
  parameter int CHANNELS  = 8,
  parameter int PWM_BITS  = 10,
  parameter int FRAC_BITS = 21,
  parameter int PRESCALE  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   hold,
  input  logic                                   mode,
  output logic [CHANNELS-1:0]                    led,
  output logic [$clog2(CHANNELS)+FRAC_BITS-1:0]  pos,
  output logic                                   dir,
  output logic                                   step
);

  localparam int SEG_BITS = $clog2(CHANNELS);
  localparam int POS_BITS = SEG_BITS + FRAC_BITS;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [POS_BITS-1:0] POS_MAX  = '1;
  localparam logic [PWM_BITS-1:0] BMAX     = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [POS_BITS-1:0] pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                step_q;
  logic                tc;
  logic [PWM_BITS-1:0] pwm_q;

  logic [PWM_BITS-1:0] bright_p1_q [CHANNELS];
  logic [PWM_BITS-1:0] bright_p1_d [CHANNELS];
  logic [CHANNELS-1:0] led_p2_q, led_p2_d;

  logic [SEG_BITS-1:0] seg;
  logic [PWM_BITS-1:0] frac;

  // Brightness of one channel; the mode decides whether the end channels see each other as neighbours.
  function automatic logic [PWM_BITS-1:0] chan_bright(input int ch,
                                                      input logic [SEG_BITS-1:0] s,
                                                      input logic [PWM_BITS-1:0] f,
                                                      input logic wrap);
    int   prv;
    int   nxt;
    logic has_prv;
    logic has_nxt;
    prv     = (ch + CHANNELS - 1) % CHANNELS;
    nxt     = (ch + 1) % CHANNELS;
    has_prv = wrap || (ch != 0);
    has_nxt = wrap || (ch != CHANNELS - 1);
    if (s == SEG_BITS'(ch))                 return BMAX;
    else if (has_prv && s == SEG_BITS'(prv)) return f;
    else if (has_nxt && s == SEG_BITS'(nxt)) return BMAX - f;
    else                                     return '0;
  endfunction

  assign tc = !hold && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    pos_d = pos_q;
    dir_d = dir_q;
    if (!hold) begin
      pre_d = tc ? '0 : pre_q + PRE_W'(1);
    end
    if (tc) begin
      if (mode) begin
        dir_d = 1'b0;
        pos_d = pos_q + POS_BITS'(1);
      end else if (!dir_q) begin
        if (pos_q == POS_MAX) begin
          dir_d = 1'b1;
          pos_d = POS_MAX - POS_BITS'(1);
        end else begin
          pos_d = pos_q + POS_BITS'(1);
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = 1'b0;
          pos_d = POS_BITS'(1);
        end else begin
          pos_d = pos_q - POS_BITS'(1);
        end
      end
    end
  end

  // Stage p0: prescaler, position accumulator and free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= tc;
      pwm_q  <= pwm_q + PWM_BITS'(1);
    end
  end

  assign seg  = pos_q[POS_BITS-1:FRAC_BITS];
  assign frac = pos_q[FRAC_BITS-1 -: PWM_BITS];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      bright_p1_d[i] = chan_bright(i, seg, frac, mode);
    end
  end

  // Stage p1: per-channel brightness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) bright_p1_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) bright_p1_q[i] <= bright_p1_d[i];
    end
  end

  always_comb begin
    led_p2_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef LED_SCANNER_FULL_ON_EN
      led_p2_d[i] = (bright_p1_q[i] == BMAX) || (pwm_q < bright_p1_q[i]);
`else
      led_p2_d[i] = (pwm_q < bright_p1_q[i]);
`endif
    end
  end

  // Stage p2: PWM compare into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_p2_q <= '0;
    else        led_p2_q <= led_p2_d;
  end

  assign led  = led_p2_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: 4 channels, 2-bit PWM, 2 fraction bits; a second instance uses PRESCALE=3.
module tb_led_scanner;

  logic       clk = 1'b0;
  logic       rst_n, hold, mode;
  logic [3:0] led, pos;
  logic       dir, step;
  logic       rst3_n, hold3, mode3;
  logic [3:0] led3, pos3;
  logic       dir3, step3;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  led_scanner #(.CHANNELS(4), .PWM_BITS(2), .FRAC_BITS(2), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .mode(mode),
    .led(led), .pos(pos), .dir(dir), .step(step));

  led_scanner #(.CHANNELS(4), .PWM_BITS(2), .FRAC_BITS(2), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .hold(hold3), .mode(mode3),
    .led(led3), .pos(pos3), .dir(dir3), .step(step3));

  // Clock edges since reset release; equals the DUT PWM counter value modulo 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  typedef struct {
    logic hold;
    logic mode;
    int   n;
    int   pos;
    logic dir;
    logic step;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hi(input int b);
`ifdef LED_SCANNER_FULL_ON_EN
    if (b == 3) return 16;
`endif
    return 4 * b;
  endfunction

  function automatic int led_exp(input int pwm, input int b);
`ifdef LED_SCANNER_FULL_ON_EN
    if (b == 3) return 1;
`endif
    return (pwm < b) ? 1 : 0;
  endfunction

  task automatic duty(input string nm, input int b0, input int b1, input int b2, input int b3);
    int c [4];
    int b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < 4; k++) c[k] = 0;
    repeat (16) begin
      tick();
      for (int k = 0; k < 4; k++) c[k] += int'(led[k]);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("%s_ch%0d", nm, k), c[k], hi(b[k]));
  endtask

  // Single step under hold, then four led samples; bright switches from old to new two edges after pos.
  task automatic latency(input string nm, input int phase, input int npos,
                         input int o0, input int o1, input int o2, input int o3,
                         input int n0, input int n1, input int n2, input int n3);
    int ob [4];
    int nb [4];
    int ev;
    int pu;
    ob[0] = o0; ob[1] = o1; ob[2] = o2; ob[3] = o3;
    nb[0] = n0; nb[1] = n1; nb[2] = n2; nb[3] = n3;
    repeat (2) tick();
    for (int k = 0; k < 4 && (edges % 4) != phase; k++) tick();
    hold = 1'b0;
    tick();
    hold = 1'b1;
    chk({nm, "_pos"}, int'(pos), npos);
    chk({nm, "_step"}, int'(step), 1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      pu = (edges - 1) % 4;
      ev = 0;
      for (int c = 0; c < 4; c++)
        ev |= led_exp(pu, (j >= 2) ? nb[c] : ob[c]) << c;
      chk($sformatf("%s_led_t%0d", nm, j), int'(led), ev);
    end
  endtask

  initial begin
    int   found;
    logic saw_hi, saw_lo;

    vt[0]  = '{1'b0, 1'b0, 14, 15, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b0,  1, 14, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 14,  0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0,  1,  1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0,  3,  4, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b0,  4,  4, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0,  2,  6, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0,  9, 15, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0,  3, 12, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1,  1, 13, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b1,  2, 15, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b1,  1,  0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b1,  2,  2, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b1,  1,  2, 1'b0, 1'b0};

    rst_n = 1'b0; hold = 1'b0; mode = 1'b0;
    rst3_n = 1'b0; hold3 = 1'b0; mode3 = 1'b0;
    repeat (2) tick();
    chk("rst_pos", int'(pos), 0);
    chk("rst_led", int'(led), 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("run_pos", int'(pos), 5);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", int'(led), 0);
    chk("arst_pos", int'(pos), 0);
    chk("arst_dir", int'(dir), 0);
    chk("arst_step", int'(step), 0);
    tick();
    chk("arst_hold_pos", int'(pos), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rel_pos", int'(pos), 1);
    chk("rel_step", int'(step), 1);
    chk("rel_dir", int'(dir), 0);

    for (int v = 0; v < 14; v++) begin
      hold = vt[v].hold;
      mode = vt[v].mode;
      repeat (vt[v].n) tick();
      chk($sformatf("v%0d_pos", v), int'(pos), vt[v].pos);
      chk($sformatf("v%0d_dir", v), int'(dir), int'(vt[v].dir));
      chk($sformatf("v%0d_step", v), int'(step), int'(vt[v].step));
    end

    // pos=2 held: seg 0, frac 2
    repeat (2) tick();
    duty("wrap_p2", 3, 2, 0, 1);
    mode = 1'b0;
    repeat (2) tick();
    duty("bnc_p2", 3, 2, 0, 0);

    hold = 1'b0;
    repeat (4) tick();
    chk("up_pos", int'(pos), 6);
    chk("up_dir", int'(dir), 0);
    hold = 1'b1;
    repeat (2) tick();
    duty("bnc_p6", 1, 3, 2, 0);

    latency("lat67", 3, 7, 1, 3, 2, 0, 0, 3, 3, 0);
    hold = 1'b0;
    tick();
    hold = 1'b1;
    chk("p8_pos", int'(pos), 8);
    latency("lat89", 2, 9, 0, 3, 3, 0, 0, 2, 3, 1);

    // Hold with PRESCALE=3
    rst3_n = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      tick();
      if (pos3 == 4'd5 && step3 == 1'b1) found = 1;
    end
    chk("p3_reach5", found, 1);
    if (found == 1) begin
      hold3 = 1'b1;
      saw_hi = 1'b0;
      saw_lo = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk($sformatf("hold_pos_%0d", k), int'(pos3), 5);
        chk($sformatf("hold_step_%0d", k), int'(step3), 0);
        if (k >= 2) begin
          if (led3[0]) saw_hi = 1'b1;
          else         saw_lo = 1'b1;
        end
      end
      chk("hold_pwm_runs", int'(saw_hi && saw_lo), 1);
      hold3 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk($sformatf("resume_step_%0d", k), int'(step3), (k == 3) ? 1 : 0);
      end
      chk("resume_pos", int'(pos3), 6);
      chk("resume_dir", int'(dir3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
